// File: rtl/frog_pkg.sv
// Shared encodings for the frog player controller: FSM states, hop directions, coordinate width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frog_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOP  = 2'd1,
    ST_DEAD = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

endpackage

// File: rtl/frog_hop_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchroniser, active-low to active-high, rising-edge pulse.
// Latency: pulse is high for one clk, two clk edges after the press reaches btn.
// Backpressure: none; a pulse not consumed in its clk is lost.
// Ports: clk, rst_n (async active-low), btn (raw active-low button), pulse (1-clk press pulse).
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  // sh[0], sh[1]: synchroniser stages; sh[2]: previous synchronised level.
  // Resets to "released" so a button held through reset yields one press after release.
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= 3'b111;
    end else begin
      sh <= {sh[1:0], btn};
    end
  end

  // Pressed now (low) and released one clk earlier (high).
  assign pulse = sh[2] & ~sh[1];

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog player controller: discrete grid hops, bound rejection, death/respawn, lives, goal scoring.
// Latency: button press to HOP entry 3 clk; hop completes STEP/SPEED animation strobes later.
// Backpressure: none; button edges arriving outside IDLE are discarded.
// Ports: i_clk, i_rst_n (async active-low), i_ani_stb/i_animate (frame timing),
//        i_*_btn (active-low buttons), i_dead (collision), i_new_game (restart pulse);
//        o_x1/o_x2/o_y1/o_y2 sprite box, o_state, o_lives, o_score, o_goal, o_game_over.
module frog_hop_ctrl
  import frog_pkg::*;
#(
  parameter int H_WIDTH        = 11,
  parameter int H_HEIGHT       = 11,
  parameter int IX             = 320,
  parameter int IY             = 460,
  parameter int D_WIDTH        = 640,
  parameter int D_HEIGHT       = 480,
  parameter int STEP           = 20,
  parameter int SPEED          = 2,
  parameter int LIVES          = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int GOAL_Y         = 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic               i_up_btn,
  input  logic               i_down_btn,
  input  logic               i_left_btn,
  input  logic               i_right_btn,
  input  logic               i_dead,
  input  logic               i_new_game,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_y2,
  output logic [1:0]         o_state,
  output logic [3:0]         o_lives,
  output logic [7:0]         o_score,
  output logic               o_goal,
  output logic               o_game_over
);

  localparam logic [COORD_W-1:0] IX_C    = COORD_W'(IX);
  localparam logic [COORD_W-1:0] IY_C    = COORD_W'(IY);
  localparam logic [COORD_W-1:0] HW_C    = COORD_W'(H_WIDTH);
  localparam logic [COORD_W-1:0] HH_C    = COORD_W'(H_HEIGHT);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] SPD_C   = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] GOAL_C  = COORD_W'(GOAL_Y);
  localparam logic [3:0]         LIVES_C = 4'(LIVES);
  localparam logic [15:0]        RESP_C  = 16'(RESPAWN_FRAMES);

  // Bound checks use one extra bit, signed, so a hop past the top/left edge goes negative
  // instead of wrapping to a large positive coordinate.
  localparam logic signed [12:0] HW_S   = $signed(13'(H_WIDTH));
  localparam logic signed [12:0] HH_S   = $signed(13'(H_HEIGHT));
  localparam logic signed [12:0] STEP_S = $signed(13'(STEP));
  localparam logic signed [12:0] XMAX_S = $signed(13'(D_WIDTH - 1));
  localparam logic signed [12:0] YMAX_S = $signed(13'(D_HEIGHT - 1));

  state_t             state;
  dir_t               dir;
  logic [COORD_W-1:0] x, y, rem;
  logic [15:0]        timer;
  logic [3:0]         lives;
  logic [7:0]         score;
  logic               goal;

  logic up_e, down_e, left_e, right_e;

  btn_edge u_up    (.clk(i_clk), .rst_n(i_rst_n), .btn(i_up_btn),    .pulse(up_e));
  btn_edge u_down  (.clk(i_clk), .rst_n(i_rst_n), .btn(i_down_btn),  .pulse(down_e));
  btn_edge u_left  (.clk(i_clk), .rst_n(i_rst_n), .btn(i_left_btn),  .pulse(left_e));
  btn_edge u_right (.clk(i_clk), .rst_n(i_rst_n), .btn(i_right_btn), .pulse(right_e));

  logic stb;
  assign stb = i_animate & i_ani_stb;

  logic signed [12:0] xs, ys;
  logic ok_up, ok_down, ok_left, ok_right;

  assign xs       = $signed({1'b0, x});
  assign ys       = $signed({1'b0, y});
  assign ok_left  = (xs - HW_S - STEP_S) >= 13'sd0;
  assign ok_right = (xs + HW_S + STEP_S) <= XMAX_S;
  assign ok_up    = (ys - HH_S - STEP_S) >= 13'sd0;
  assign ok_down  = (ys + HH_S + STEP_S) <= YMAX_S;

  // Only the highest-priority edge is considered; if it is out of bounds the whole
  // request is dropped rather than falling back to a lower-priority direction.
  logic req, req_ok;
  dir_t req_dir;

  always_comb begin
    req     = 1'b0;
    req_ok  = 1'b0;
    req_dir = DIR_UP;
    if (up_e) begin
      req = 1'b1; req_dir = DIR_UP;    req_ok = ok_up;
    end else if (down_e) begin
      req = 1'b1; req_dir = DIR_DOWN;  req_ok = ok_down;
    end else if (left_e) begin
      req = 1'b1; req_dir = DIR_LEFT;  req_ok = ok_left;
    end else if (right_e) begin
      req = 1'b1; req_dir = DIR_RIGHT; req_ok = ok_right;
    end
  end

  // Position after one animation step in the latched direction.
  logic [COORD_W-1:0] nx, ny;

  always_comb begin
    nx = x;
    ny = y;
    case (dir)
      DIR_UP:    ny = y - SPD_C;
      DIR_DOWN:  ny = y + SPD_C;
      DIR_LEFT:  nx = x - SPD_C;
      DIR_RIGHT: nx = x + SPD_C;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      dir   <= DIR_UP;
      x     <= IX_C;
      y     <= IY_C;
      rem   <= '0;
      timer <= '0;
      lives <= LIVES_C;
      score <= '0;
      goal  <= 1'b0;
    end else begin
      goal <= 1'b0;
      if (i_new_game) begin
        state <= ST_IDLE;
        dir   <= DIR_UP;
        x     <= IX_C;
        y     <= IY_C;
        rem   <= '0;
        timer <= '0;
        lives <= LIVES_C;
        score <= '0;
      end else if (i_dead && (state == ST_IDLE || state == ST_HOP)) begin
        // Death beats a same-clk final hop strobe: position freezes, no score.
        state <= ST_DEAD;
        rem   <= '0;
        timer <= RESP_C;
        lives <= (lives == 4'd0) ? 4'd0 : lives - 4'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req && req_ok) begin
              state <= ST_HOP;
              dir   <= req_dir;
              rem   <= STEP_C;
            end
          end
          ST_HOP: begin
            if (stb) begin
              if (rem <= SPD_C) begin
                rem   <= '0;
                state <= ST_IDLE;
                if (dir == DIR_UP && ny <= GOAL_C) begin
                  goal  <= 1'b1;
                  score <= (score == 8'hFF) ? score : score + 8'd1;
                  x     <= IX_C;
                  y     <= IY_C;
                end else begin
                  x <= nx;
                  y <= ny;
                end
              end else begin
                rem <= rem - SPD_C;
                x   <= nx;
                y   <= ny;
              end
            end
          end
          ST_DEAD: begin
            if (stb) begin
              if (timer <= 16'd1) begin
                timer <= '0;
                if (lives == 4'd0) begin
                  state <= ST_OVER;
                end else begin
                  state <= ST_IDLE;
                  x     <= IX_C;
                  y     <= IY_C;
                end
              end else begin
                timer <= timer - 16'd1;
              end
            end
          end
          default: state <= ST_OVER;
        endcase
      end
    end
  end

  assign o_x1        = x - HW_C;
  assign o_x2        = x + HW_C;
  assign o_y1        = y - HH_C;
  assign o_y2        = y + HH_C;
  assign o_state     = state;
  assign o_lives     = lives;
  assign o_score     = score;
  assign o_goal      = goal;
  assign o_game_over = (state == ST_OVER);

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Testbench for frog_hop_ctrl: directed stimulus with expected state transitions queued
// as they are issued; a monitor pops and compares on every state change or goal pulse.
module tb_frog_hop_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ani_stb = 1'b0, animate = 1'b1;
  logic        up_btn = 1'b1, down_btn = 1'b1, left_btn = 1'b1, right_btn = 1'b1;
  logic        dead = 1'b0, new_game = 1'b0;
  logic [11:0] o_x1, o_x2, o_y1, o_y2;
  logic [1:0]  o_state;
  logic [3:0]  o_lives;
  logic [7:0]  o_score;
  logic        o_goal, o_game_over;

  int checks = 0;
  int errors = 0;

  frog_hop_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
    .i_up_btn(up_btn), .i_down_btn(down_btn), .i_left_btn(left_btn), .i_right_btn(right_btn),
    .i_dead(dead), .i_new_game(new_game),
    .o_x1(o_x1), .o_x2(o_x2), .o_y1(o_y1), .o_y2(o_y2),
    .o_state(o_state), .o_lives(o_lives), .o_score(o_score),
    .o_goal(o_goal), .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    st;
    int    cx;
    int    cy;
    int    lives;
    int    score;
    int    goal;
    int    stb;   // strobes since previous transition; -1 = don't care
  } rec_t;

  rec_t evq[$];
  rec_t snapq[$];
  event snap_ev;

  function automatic rec_t mk(string n, int st, int cx, int cy, int lv, int sc, int g, int s);
    rec_t r;
    r.name = n; r.st = st; r.cx = cx; r.cy = cy;
    r.lives = lv; r.score = sc; r.goal = g; r.stb = s;
    return r;
  endfunction

  task automatic check_rec(input rec_t e, input int stb);
    bit ok;
    checks++;
    ok = (int'(o_state) == e.st) &&
         (int'(o_x1) == e.cx - 11) && (int'(o_x2) == e.cx + 11) &&
         (int'(o_y1) == e.cy - 11) && (int'(o_y2) == e.cy + 11) &&
         (int'(o_lives) == e.lives) && (int'(o_score) == e.score) &&
         (int'(o_goal) == e.goal) && (o_game_over == (e.st == 3)) &&
         (e.stb < 0 || stb == e.stb);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got st=%0d x1=%0d x2=%0d y1=%0d y2=%0d lives=%0d score=%0d goal=%0d over=%0d stb=%0d; want st=%0d cx=%0d cy=%0d lives=%0d score=%0d goal=%0d stb=%0d",
               e.name, o_state, o_x1, o_x2, o_y1, o_y2, o_lives, o_score, o_goal, o_game_over, stb,
               e.st, e.cx, e.cy, e.lives, e.score, e.goal, e.stb);
    end
  endtask

  // Transition monitor: a change of o_state or a goal pulse is one DUT output event.
  initial begin : monitor
    rec_t       e;
    logic [1:0] prev;
    int         cnt;
    prev = 2'd0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 2'd0;
        cnt  = 0;
      end else begin
        if (o_state != prev || o_goal) begin
          if (evq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got st=%0d prev=%0d goal=%0d y1=%0d x1=%0d lives=%0d, want no transition",
                     o_state, prev, o_goal, o_y1, o_x1, o_lives);
          end else begin
            e = evq.pop_front();
            check_rec(e, cnt);
          end
          cnt = 0;
        end
        prev = o_state;
        if (ani_stb && animate) cnt++;
      end
    end
  end

  // Snapshot monitor: compares the full output set on request (also usable inside reset).
  initial begin : snap_monitor
    rec_t e;
    forever begin
      @(snap_ev);
      if (snapq.size() != 0) begin
        e = snapq.pop_front();
        check_rec(e, -1);
      end
    end
  end

  task automatic snap(input rec_t r);
    snapq.push_back(r);
    ->snap_ev;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      ani_stb = 1'b1;
      tick(1);
      ani_stb = 1'b0;
      tick(3);
    end
  endtask

  task automatic press(input bit u, input bit d, input bit l, input bit r);
    up_btn = ~u; down_btn = ~d; left_btn = ~l; right_btn = ~r;
    tick(4);
  endtask

  task automatic release_all();
    up_btn = 1'b1; down_btn = 1'b1; left_btn = 1'b1; right_btn = 1'b1;
    tick(4);
  endtask

  task automatic pulse_dead();
    dead = 1'b1;
    tick(1);
    dead = 1'b0;
    tick(1);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick(1);
    new_game = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (evq.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (evq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: got %0d expected transitions still pending (next %s), want 0",
               tag, evq.size(), evq[0].name);
      evq.delete();
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset state, checked while reset is still asserted and again after release.
    tick(2);
    snap(mk("reset_in", 0, 320, 460, 3, 0, 0, -1));
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick(2);
    snap(mk("reset_out", 0, 320, 460, 3, 0, 0, -1));

    // Down from home is out of bounds: 460+11+20 = 491 > 479.
    press(0, 1, 0, 0);
    frames(3);
    release_all();
    drain("down_reject");
    snap(mk("down_reject", 0, 320, 460, 3, 0, 0, -1));

    // Held up button for 50 frames: exactly one hop of 10 strobes.
    evq.push_back(mk("up_start", 1, 320, 460, 3, 0, 0, -1));
    evq.push_back(mk("up_end",   0, 320, 440, 3, 0, 0, 10));
    press(1, 0, 0, 0);
    frames(50);
    release_all();
    drain("up_held");
    snap(mk("up_held", 0, 320, 440, 3, 0, 0, -1));

    // Five left hops: 320 -> 220.
    for (int i = 0; i < 5; i++) begin
      evq.push_back(mk("left_start", 1, 320 - 20 * i, 440, 3, 0, 0, -1));
      evq.push_back(mk("left_end",   0, 300 - 20 * i, 440, 3, 0, 0, 10));
      press(0, 0, 1, 0);
      frames(10);
      release_all();
    end
    drain("left");
    snap(mk("left_x5", 0, 220, 440, 3, 0, 0, -1));

    // New game returns home.
    pulse_new_game();
    snap(mk("new_game_1", 0, 320, 460, 3, 0, 0, -1));

    // Death mid-hop after 5 strobes (y=450), respawn after 60 strobes.
    evq.push_back(mk("d1_hop",   1, 320, 460, 3, 0, 0, -1));
    evq.push_back(mk("d1_dead",  2, 320, 450, 2, 0, 0, 5));
    evq.push_back(mk("d1_respawn", 0, 320, 460, 2, 0, 0, 60));
    press(1, 0, 0, 0);
    frames(5);
    pulse_dead();
    release_all();
    frames(60);
    drain("death1");

    // Two more deaths: lives 1 then 0 -> OVER.
    evq.push_back(mk("d2_dead",    2, 320, 460, 1, 0, 0, -1));
    evq.push_back(mk("d2_respawn", 0, 320, 460, 1, 0, 0, 60));
    evq.push_back(mk("d3_dead",    2, 320, 460, 0, 0, 0, -1));
    evq.push_back(mk("d3_over",    3, 320, 460, 0, 0, 0, 60));
    pulse_dead();
    frames(60);
    pulse_dead();
    frames(60);
    drain("death23");

    // In OVER buttons and i_dead are ignored.
    press(1, 0, 1, 0);
    frames(12);
    pulse_dead();
    release_all();
    drain("over_idle");
    snap(mk("over_hold", 3, 320, 460, 0, 0, 0, -1));

    evq.push_back(mk("new_game_2", 0, 320, 460, 3, 0, 0, -1));
    pulse_new_game();
    drain("new_game_2");

    // 22 up hops; first one with up+left together (up wins); last one reaches y=20 and scores.
    evq.push_back(mk("g_start0", 1, 320, 460, 3, 0, 0, -1));
    evq.push_back(mk("g_end0",   0, 320, 440, 3, 0, 0, 10));
    press(1, 0, 1, 0);
    frames(10);
    release_all();
    for (int k = 1; k < 22; k++) begin
      evq.push_back(mk("g_start", 1, 320, 460 - 20 * k, 3, 0, 0, -1));
      if (k == 21)
        evq.push_back(mk("g_goal", 0, 320, 460, 3, 1, 1, 10));
      else
        evq.push_back(mk("g_end", 0, 320, 440 - 20 * k, 3, 0, 0, 10));
      press(1, 0, 0, 0);
      frames(10);
      release_all();
    end
    drain("goal");
    snap(mk("after_goal", 0, 320, 460, 3, 1, 0, -1));

    // Asynchronous reset mid-hop (y=454), checked before any clock edge.
    evq.push_back(mk("ar_hop", 1, 320, 460, 3, 1, 0, -1));
    press(1, 0, 0, 0);
    frames(3);
    drain("ar_hop");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    snap(mk("async_reset", 0, 320, 460, 3, 0, 0, -1));
    release_all();
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick(4);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
